// File: rtl/mem_responder.sv
// mem_responder
//   Memory-side end of the fetch/load handshake. A request is captured in IDLE,
//   and the access then waits LATENCY extra cycles. odv is then raised with the
//   read data. Writes also raise odv, with rdata showing the value just written.
//   The same module serves both instruction and data memory.
//
// Build option
//   ODV_HOLD_EN : when defined, odv stays high until ack is sampled high.
//                 When undefined, odv is a single-cycle pulse and ack is ignored.
//
// Ports
//   g_clk  in   system clock, rising edge
//   g_clr  in   asynchronous active-high reset
//   req    in   request strobe, only looked at in IDLE
//   we     in   1 = write, 0 = read (sampled with req)
//   addr   in   word address (sampled with req)
//   wdata  in   write data (sampled with req)
//   ack    in   requester consumed odv (ODV_HOLD_EN builds only)
//   rdata  out  read data, valid while odv = 1, held otherwise
//   odv    out  output data valid / write done
//   busy   out  high in every state except IDLE
//
// state   | meaning
// --------+----------------------------------------------------------
// S_IDLE  | waiting for req; the capture edge also commits writes
// S_WAIT  | counting down access latency; rdata loaded on exit edge
// S_VALID | odv high; leaves after one cycle, or on ack with hold

module mem_responder #(
   parameter int AW      = 8,
   parameter int DW      = 32,
   parameter int LATENCY = 2
) (
   input  logic          g_clk,
   input  logic          g_clr,
   input  logic          req,
   input  logic          we,
   input  logic [AW-1:0] addr,
   input  logic [DW-1:0] wdata,
   input  logic          ack,
   output logic [DW-1:0] rdata,
   output logic          odv,
   output logic          busy
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_WAIT  = 2'd1,
      S_VALID = 2'd2
   } state_t;

   localparam logic [3:0] LAT = 4'(LATENCY);

   state_t        r_state;
   state_t        w_next;
   logic [3:0]    r_cnt;
   logic [AW-1:0] r_addr;
   logic [DW-1:0] r_rdata;
   logic          r_odv;
   logic          r_busy;
   logic [DW-1:0] r_mem [0:(1<<AW)-1];

   logic w_capture;
   logic w_wait_done;

   assign w_capture   = (r_state == S_IDLE) && req;
   // WAIT always lasts at least one cycle, even with LATENCY = 0. The registered
   // read happens on its exit edge, which gives the fixed LATENCY+1 response.
   assign w_wait_done = (r_state == S_WAIT) && (r_cnt == 4'd0);

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (req) w_next = S_WAIT;
         S_WAIT:  if (w_wait_done) w_next = S_VALID;
`ifdef ODV_HOLD_EN
         S_VALID: if (ack) w_next = S_IDLE;
`else
         S_VALID: w_next = S_IDLE;
`endif
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge g_clk or posedge g_clr) begin
      if (g_clr) begin
         r_state <= S_IDLE;
         r_cnt   <= 4'd0;
         r_addr  <= '0;
         r_rdata <= '0;
         r_odv   <= 1'b0;
         r_busy  <= 1'b0;
      end else begin
         r_state <= w_next;
         r_odv   <= (w_next == S_VALID);
         r_busy  <= (w_next != S_IDLE);
         if (w_capture) begin
            r_addr <= addr;
            r_cnt  <= LAT;
         end else if ((r_state == S_WAIT) && (r_cnt != 4'd0)) begin
            r_cnt <= r_cnt - 4'd1;
         end
         // The write was committed at capture, so this read returns the new
         // value for writes as well as reads.
         if (w_wait_done) r_rdata <= r_mem[r_addr];
      end
   end

   // Storage has no reset; contents survive g_clr.
   always_ff @(posedge g_clk) begin
      if (w_capture && we) r_mem[addr] <= wdata;
   end

   assign rdata = r_rdata;
   assign odv   = r_odv;
   assign busy  = r_busy;

endmodule
